// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 16-bit MIPS core, with load-use hazard detection.
// Latency: one cycle from ID inputs to ex_* outputs. stall_id is combinational.
// Backpressure: ex_hold freezes the stage. A load-use hazard stalls IF/ID for one cycle and inserts a bubble.
//
// Ports:
//   clk, rst (async active-low)
//   id_* : decode bundle (valid, rs/rt/rd, uses_rt, rs/rt data, extended immediate, ctrl)
//   flush : kill the instruction entering or held in EX
//   ex_hold : execute stage cannot accept; freeze this register
//   stall_id : IF/ID and PC hold this cycle
//   ex_* : registered bundle presented to execute
//   stall_count : saturating count of hazard-stall cycles
// ctrl layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [7:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MEM_READ_BIT = 6;

  logic              ex_valid_q,   ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [7:0]        ex_ctrl_q,    ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic ex_is_load;
  logic rs_match;
  logic rt_match;
  logic hazard;

  // A load targeting r0 never produces a value worth waiting for.
  assign ex_is_load = ex_valid_q && ex_ctrl_q[MEM_READ_BIT] && (ex_rt_q != '0);
  assign rs_match   = (ex_rt_q == id_rs);
  assign rt_match   = id_uses_rt && (ex_rt_q == id_rt);
  assign hazard     = ex_is_load && id_valid && (rs_match || rt_match);
  assign stall_id   = hazard && !flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      // Flush wins over hold: the killed slot must not keep live control.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else if (ex_hold) begin
      // Everything frozen; stall_id still reflects the hazard.
    end else if (hazard) begin
      // Bubble: clearing ctrl keeps reg_write/mem_write from leaking into EX.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else begin
      ex_valid_d   = id_valid;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_rd;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm_ext;
      ex_ctrl_d    = id_valid ? id_ctrl : 8'h00;
    end

    // Count only stall cycles that actually cost an issue slot.
    if (stall_id && !ex_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a cycle model of the pipeline slot
// checked every negedge, and literal expectations at key points.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_uses_rt = 1'b0;
  logic [15:0] id_rs_data = '0, id_rt_data = '0, id_imm_ext = '0;
  logic [7:0]  id_ctrl = '0;
  logic        flush = 1'b0, ex_hold = 1'b0;
  logic        stall_id, ex_valid;
  logic [3:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [7:0]  stall_count;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_ctrl(id_ctrl),
    .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: what the EX slot must contain ----------------
  typedef struct {
    bit       valid;
    int       rs, rt, rd;
    int       rs_data, rt_data, imm;
    int       ctrl;
  } slot_t;

  slot_t m_slot = '{0, 0, 0, 0, 0, 0, 0, 0};
  int    m_cnt  = 0;

  // The instruction in EX is a load whose result the ID instruction needs.
  function automatic bit m_hazard();
    bit is_load;
    is_load = m_slot.valid && ((m_slot.ctrl / 64) % 2 == 1) && m_slot.rt != 0;
    return is_load && id_valid &&
           (m_slot.rt == int'(id_rs) || (id_uses_rt && m_slot.rt == int'(id_rt)));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot <= '{0, 0, 0, 0, 0, 0, 0, 0};
      m_cnt  <= 0;
    end else begin
      if (m_hazard() && !flush && !ex_hold)
        m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      if (flush || (!ex_hold && m_hazard())) begin
        m_slot.valid <= 0;
        m_slot.ctrl  <= 0;
      end else if (!ex_hold) begin
        m_slot <= '{id_valid, int'(id_rs), int'(id_rt), int'(id_rd), int'(id_rs_data),
                    int'(id_rt_data), int'(id_imm_ext), id_valid ? int'(id_ctrl) : 0};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("m_stall_id", 32'(stall_id), 32'(m_hazard() && !flush));
      chk("m_ex_valid", 32'(ex_valid), 32'(m_slot.valid));
      chk("m_ex_ctrl", 32'(ex_ctrl), m_slot.ctrl);
      chk("m_stall_count", 32'(stall_count), m_cnt);
      if (m_slot.valid) begin
        chk("m_ex_rs", 32'(ex_rs), m_slot.rs);
        chk("m_ex_rt", 32'(ex_rt), m_slot.rt);
        chk("m_ex_rd", 32'(ex_rd), m_slot.rd);
        chk("m_ex_rs_data", 32'(ex_rs_data), m_slot.rs_data);
        chk("m_ex_rt_data", 32'(ex_rt_data), m_slot.rt_data);
        chk("m_ex_imm", 32'(ex_imm), m_slot.imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic urt, input logic [15:0] rsd,
                       input logic [15:0] rtd, input logic [15:0] imm, input logic [7:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm; id_ctrl = ctrl;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 0);
    chk({tag, "_ctrl"}, 32'(ex_ctrl), 0);
    chk({tag, "_fields"}, 32'(ex_rs | ex_rt | ex_rd), 0);
    chk({tag, "_data"}, 32'(ex_rs_data | ex_rt_data | ex_imm), 0);
    chk({tag, "_count"}, 32'(stall_count), 0);
    chk({tag, "_stall"}, 32'(stall_id), 0);
  endtask

  // lw r5 <- mem[r1]; ctrl = reg_write|mem_read|mem_to_reg|alu_src
  localparam logic [7:0] LOAD_CTRL = 8'hD8;
  localparam logic [7:0] ALU_CTRL  = 8'h81;

  initial begin
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b1;
    chk_en = 1'b1;

    // Pass-through
    drive(1, 4'd2, 4'd3, 4'd4, 1, 16'h1234, 16'h5678, 16'hFFF8, ALU_CTRL);
    step();
    chk("pt_valid", 32'(ex_valid), 1);
    chk("pt_rs", 32'(ex_rs), 2);
    chk("pt_rt", 32'(ex_rt), 3);
    chk("pt_rs_data", 32'(ex_rs_data), 32'h1234);
    chk("pt_imm", 32'(ex_imm), 32'hFFF8);
    chk("pt_ctrl", 32'(ex_ctrl), 32'h81);

    // Load-use on rs
    drive(1, 4'd1, 4'd5, 4'd0, 0, 16'h0010, 16'h0000, 16'h0004, LOAD_CTRL);
    step();
    drive(1, 4'd5, 4'd6, 4'd7, 1, 16'hAAAA, 16'hBBBB, 16'h0000, ALU_CTRL);
    #1 chk("lu_stall_before", 32'(stall_id), 1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_ctrl", 32'(ex_ctrl), 0);
    chk("lu_count", 32'(stall_count), 1);
    #1 chk("lu_stall_after", 32'(stall_id), 0);
    step();
    chk("lu_issue_valid", 32'(ex_valid), 1);
    chk("lu_issue_rs", 32'(ex_rs), 5);
    chk("lu_issue_ctrl", 32'(ex_ctrl), 32'h81);

    // No false stall: load to r0, then rt match without uses_rt
    drive(1, 4'd1, 4'd0, 4'd0, 0, 16'h0001, 16'h0000, 16'h0000, LOAD_CTRL);
    step();
    drive(1, 4'd0, 4'd0, 4'd3, 1, 16'h0000, 16'h0000, 16'h0000, ALU_CTRL);
    #1 chk("nf_r0_stall", 32'(stall_id), 0);
    drive(1, 4'd1, 4'd5, 4'd0, 0, 16'h0002, 16'h0000, 16'h0000, LOAD_CTRL);
    step();
    drive(1, 4'd7, 4'd5, 4'd3, 0, 16'h0003, 16'h0004, 16'h0000, ALU_CTRL);
    #1 chk("nf_rt_stall", 32'(stall_id), 0);
    step();
    chk("nf_rt_issued", 32'(ex_rs), 7);

    // Flush beats hold and hazard
    drive(1, 4'd1, 4'd5, 4'd0, 0, 16'h0002, 16'h0000, 16'h0000, LOAD_CTRL);
    step();
    drive(1, 4'd5, 4'd2, 4'd3, 1, 16'h0000, 16'h0000, 16'h0000, ALU_CTRL);
    flush = 1; ex_hold = 1;
    #1 chk("fl_stall", 32'(stall_id), 0);
    step();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_ctrl", 32'(ex_ctrl), 0);
    chk("fl_count", 32'(stall_count), 1);
    flush = 0; ex_hold = 0;

    // Hold with a hazard present for 3 cycles
    drive(1, 4'd1, 4'd5, 4'd0, 0, 16'h00C0, 16'h0000, 16'h0008, LOAD_CTRL);
    step();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd5, 4'(i + 8), 4'(i + 1), 1, 16'(i * 3), 16'(i * 7), 16'(i), ALU_CTRL);
      #1 chk("hd_stall", 32'(stall_id), 1);
      step();
      chk("hd_valid", 32'(ex_valid), 1);
      chk("hd_rt", 32'(ex_rt), 5);
      chk("hd_rs_data", 32'(ex_rs_data), 32'h00C0);
      chk("hd_ctrl", 32'(ex_ctrl), 32'hD8);
      chk("hd_count", 32'(stall_count), 1);
    end
    ex_hold = 0;
    step();
    chk("hd_release_bubble", 32'(ex_valid), 0);
    chk("hd_release_count", 32'(stall_count), 2);
    step();
    chk("hd_release_issue", 32'(ex_rs), 5);

    // Saturation: self-dependent load stalls every other cycle
    drive(1, 4'd5, 4'd5, 4'd0, 0, 16'h0100, 16'h0000, 16'h0002, LOAD_CTRL);
    repeat (600) step();
    chk("sat_count", 32'(stall_count), 255);

    // Async reset mid-cycle, while a stall is active
    @(posedge clk);
    #3 rst = 0;
    #1 check_all_zero("arst");
    step();
    rst = 1;
    drive(1, 4'd2, 4'd3, 4'd4, 1, 16'h1234, 16'h5678, 16'hFFF8, ALU_CTRL);
    step();
    chk("post_rst_valid", 32'(ex_valid), 1);
    chk("post_rst_rs_data", 32'(ex_rs_data), 32'h1234);
    chk("post_rst_ctrl", 32'(ex_ctrl), 32'h81);

    id_valid = 0;
    repeat (3) step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-bit pipelined MIPS core, directly downstream of the sign-extend unit.
- Captures the decode-stage bundle (register operands, sign-extended immediate, control fields) each cycle and presents it to the execute stage.
- Detects load-use hazards against the instruction it currently holds. On a hazard it stalls upstream and inserts a bubble.
- Supports branch flush, downstream hold, and a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 16, datapath width of operands and extended immediate
- REG_AW, 4, register-specifier width (16 registers, r0 hardwired zero)
- CNT_W, 8, width of the stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset; stage clears when rst=0
- id_valid  in  1  decode-stage instruction valid
- id_rs  in  REG_AW  source register 1 specifier
- id_rt  in  REG_AW  source register 2 / load destination specifier
- id_rd  in  REG_AW  R-type destination specifier
- id_uses_rt  in  1  instruction reads rt as a source
- id_rs_data  in  DATA_W  register-file read data for rs
- id_rt_data  in  DATA_W  register-file read data for rt
- id_imm_ext  in  DATA_W  sign-extended immediate from the sign-extend unit
- id_ctrl  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
- flush  in  1  branch taken; kill the instruction entering/held in EX
- ex_hold  in  1  execute stage cannot accept; freeze this register
- stall_id  out  1  combinational; IF/ID and PC must hold this cycle
- ex_valid  out  1  registered valid
- ex_rs, ex_rt, ex_rd  out  REG_AW each  registered specifiers
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered data
- ex_ctrl  out  8  registered control
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, asynchronous): every registered output clears to 0, including ex_valid, ex_ctrl and stall_count. stall_id is then 0 because ex_valid=0.
- Latency: one cycle, ID inputs at edge N appear on ex_* after edge N.
- Hazard (combinational), all of the following true:
  - ex_valid=1, ex_ctrl.mem_read=1 and ex_rt!=0;
  - id_valid=1;
  - ex_rt==id_rs, or (id_uses_rt=1 and ex_rt==id_rt).
- stall_id = hazard & ~flush.
- Per-edge priority (highest first):
  1. flush=1: ex_valid<=0 and ex_ctrl<=0; other fields don't-care. Overrides ex_hold.
  2. ex_hold=1: all ex_* keep their values. stall_id is still driven as computed.
  3. hazard=1: bubble, ex_valid<=0 and ex_ctrl<=0. The held load advances in EX, so the next cycle re-evaluates with the bubble and stall_id drops.
  4. Otherwise: load all ID fields and set ex_valid<=id_valid. ex_ctrl<=id_ctrl when id_valid=1, else 0.
- Bubble invariant: ex_valid=0 implies ex_ctrl=0, so no spurious reg_write or mem_write reaches EX.
- stall_count increments on each edge where stall_id=1 and ex_hold=0, and saturates at all-ones (255 by default, no wrap).
- A load-use stall lasts exactly one cycle when ex_hold=0. Under ex_hold it persists until the hold drops.
- r0 as destination never causes a stall.
- Reset asserted mid-stall clears immediately. After release the first edge loads the ID bundle normally.

Test Plan:
- Reset then pass-through: after rst 0->1, drive id_valid=1, rs=2, rt=3, rs_data=16'h1234, imm=16'hFFF8, ctrl=8'h81. One edge later ex_* match, ex_valid=1.
- Load-use: EX holds a load (mem_read=1, rt=5). ID presents rs=5 → stall_id=1; next edge ex_valid=0, ex_ctrl=0, stall_count=1. Following cycle stall_id=0 and the instruction loads.
- No false stall: EX load with rt=0 and id_rs=0 → stall_id=0. Same with ex_rt=5, id_rt=5, id_uses_rt=0 → no stall.
- Flush priority: flush=1 together with ex_hold=1 and a hazard → stall_id=0; next edge ex_valid=0 and ex_ctrl=0.
- Hold: ex_hold=1 for 3 cycles with changing ID inputs → ex_* frozen. With a hazard present, stall_id stays 1 throughout and stall_count does not increment.
- Saturation and async reset: force 260 stall cycles → stall_count=255. Pulse rst low between edges → all outputs 0 immediately, without waiting for a clock edge.
